// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative cipher datapaths.
// Contents: FSM state encodings, round-constant lookup, GF(2^8) helpers (xtime, gf_mul, gf_inv),
// S-box and inverse S-box byte functions, and the AES-128 key-expansion step.
// All GF(2^8) arithmetic is modulo x^8+x^4+x^3+x+1.
package aes_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] EXPAND = 3'd1;
  localparam logic [2:0] ADDKEY = 3'd2;
  localparam logic [2:0] ROUNDS = 3'd3;
  localparam logic [2:0] FINAL  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // Round constant for key-expansion step i (1..10).
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // S-box built from the inverse and the affine map, avoiding a hand-typed table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // One AES-128 key-schedule step: previous round key -> next round key.
  function automatic logic [127:0] key_exp(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// Ports:
//   st_in  [127:0] round input state, byte 0 in [127:120], column-major
//   rk     [127:0] round key
//   last           bypass InvMixColumns (final round)
//   st_out [127:0] round output state
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_out
);

  localparam logic [7:0] IMC_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  logic [7:0] w_ark [16];
  logic [7:0] w_mix [16];

  always_comb begin
    for (int n = 0; n < 16; n++) begin
      // Byte n sits at row n%4, column n/4; row r rotates right by r.
      w_ark[n] = inv_sbox(st_in[127 - 8 * ((n % 4) + 4 * (((n / 4) - (n % 4) + 4) % 4)) -: 8])
                 ^ rk[127 - 8 * n -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_mix[4 * c + r] = '0;
        for (int k = 0; k < 4; k++) begin
          w_mix[4 * c + r] = w_mix[4 * c + r] ^ gf_mul(IMC_COEF[k], w_ark[4 * c + ((r + k) % 4)]);
        end
      end
    end
    st_out = '0;
    for (int n = 0; n < 16; n++) begin
      st_out[127 - 8 * n -: 8] = last ? w_ark[n] : w_mix[n];
    end
  end

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryption, one inverse round per clock.
// Expands the key forward once into rk[0..10], then applies the round keys in reverse.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   ciphertext+key request handshake (in_ready high only in IDLE)
//   ciphertext, key       128-bit inputs, byte 0 in [127:120]
//   out_valid / out_ready plaintext handshake; plaintext held until consumed
//   plaintext             decrypted block
//   busy                  high whenever not IDLE
// Optional feature: define AES_DEC_KEY_CACHE_EN to skip key expansion when the key repeats.
module aes128_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned  NR      = 10,
  parameter logic [127:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  if (NR != 10) begin : g_bad_nr
    $error("aes128_inv_cipher_iter supports only NR = 10");
  end

  logic [2:0]   r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_rk [11];
  logic [127:0] r_st;
  logic [127:0] r_pt;
  logic         r_out_valid;

  logic [127:0] w_rk_sel;
  logic [127:0] w_rk_next;
  logic [127:0] w_round;
  logic         w_last;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_cache_key;
  logic         r_cache_vld;
  logic         w_hit;
  assign w_hit = r_cache_vld && (key == r_cache_key);
`endif

  assign w_last    = (r_state == FINAL);
  assign w_rk_sel  = w_last ? r_rk[0] : r_rk[r_cnt];
  // During EXPAND r_cnt counts up 1..10 as the key-schedule index.
  assign w_rk_next = key_exp(r_rk[r_cnt - 4'd1], rcon(r_cnt));

  aes_inv_round u_round (
    .st_in  (r_st),
    .rk     (w_rk_sel),
    .last   (w_last),
    .st_out (w_round)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_st        <= '0;
      r_pt        <= RST_VAL;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      r_cache_key <= '0;
      r_cache_vld <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_st    <= ciphertext;
            r_rk[0] <= key;
            r_cnt   <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
            r_state <= w_hit ? ADDKEY : EXPAND;
`else
            r_state <= EXPAND;
`endif
          end
        end
        EXPAND: begin
          r_rk[r_cnt] <= w_rk_next;
          if (r_cnt == 4'd10) begin
            r_state <= ADDKEY;
`ifdef AES_DEC_KEY_CACHE_EN
            r_cache_key <= r_rk[0];
            r_cache_vld <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ADDKEY: begin
          r_st    <= r_st ^ r_rk[10];
          r_cnt   <= 4'd9;
          r_state <= ROUNDS;
        end
        ROUNDS: begin
          r_st <= w_round;
          if (r_cnt == 4'd1) r_state <= FINAL;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        FINAL: begin
          r_pt        <= w_round;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign plaintext = r_pt;

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
module tb_aes128_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  aes128_inv_cipher_iter #(
    .NR      (10),
    .RST_VAL ('0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] pt;
    int unsigned  lat;
    int unsigned  acc;
  } exp_t;
  exp_t sb[$];

  logic [127:0] m_key;
  bit           m_vld = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Carry-less product followed by polynomial reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8]
               ^ c[i];
      sbox_t[a]  = s;
      isbox_t[s] = 8'(a);
    end
  endtask

  // FIPS-197 InvCipher on a 4x4 state array with a word-based key schedule.
  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = ct[127 - 8 * (4 * c + r) -: 8] ^ w[40 + c][31 - 8 * r -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][(c + r) % 4] = isbox_t[s[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = t[r][c] ^ w[4 * rnd + c][31 - 8 * r -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r][c] = gmul(8'h0e, t[r][c]) ^ gmul(8'h0b, t[(r + 1) % 4][c])
                    ^ gmul(8'h0d, t[(r + 2) % 4][c]) ^ gmul(8'h09, t[(r + 3) % 4][c]);
      end else begin
        s = t;
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127 - 8 * (4 * c + r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares every presented plaintext against the scoreboard head.
  bit           prev_valid = 0;
  bit           chk_idle   = 0;
  logic [127:0] held_pt;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 0;
      chk_idle   = 0;
    end else begin
      if (chk_idle) begin
        chk("post_hs_out_valid", 128'(out_valid), 128'd0);
        chk("post_hs_in_ready", 128'(in_ready), 128'd1);
        chk_idle = 0;
      end
      if (out_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h want none", plaintext);
          end else begin
            e = sb.pop_front();
            chk("plaintext", plaintext, e.pt);
            chk("latency", 128'(cyc - e.acc + 1), 128'(e.lat));
          end
          held_pt = plaintext;
        end else begin
          chk("pt_stable", plaintext, held_pt);
          chk("in_ready_while_done", 128'(in_ready), 128'd0);
        end
        if (out_ready) chk_idle = 1;
      end
      prev_valid = out_valid;
    end
  end

  // Issue one request; called at posedge+1.
  task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
`ifdef AES_DEC_KEY_CACHE_EN
    if (m_vld && m_key == k) e.lat = 12;
    else begin
      e.lat = 22;
      m_key = k;
      m_vld = 1;
    end
`else
    e.lat = 22;
`endif
    e.pt  = p;
    e.acc = cyc + 1;
    sb.push_back(e);
    in_valid   = 1'b1;
    ciphertext = c;
    key        = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for completion; rdy_mode 0 = always ready, 1 = random. scr scrambles inputs while busy.
  task automatic wait_done(input int rdy_mode, input bit scr);
    int n;
    n = 0;
    while (busy && n < 200) begin
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (scr) begin
        in_valid   = 1'($urandom_range(0, 1));
        ciphertext = rnd128();
        key        = rnd128();
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: busy got 1 want 0");
    end
  endtask

  task automatic reset_mid(input int at);
    logic [127:0] c, k;
    c = rnd128();
    k = rnd128();
    send(c, k, ref_dec(c, k));
    repeat (at - 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    m_vld = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_busy_after", 128'(busy), 128'd0);
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] c, k, last_k;
    int           n;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_plaintext", plaintext, 128'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);

    // Known-answer vectors; the second B run hits the key cache when enabled.
    send(CT_B, KEY_B, PT_B);
    wait_done(0, 0);
    send(CT_B, KEY_B, PT_B);
    wait_done(0, 0);
    send(CT_C, KEY_C, PT_C);
    wait_done(0, 0);

    // Backpressure: hold out_ready low for 5 cycles of out_valid.
    c = rnd128();
    out_ready = 1'b0;
    send(c, KEY_C, ref_dec(c, KEY_C));
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("bp_out_valid_held", 128'(out_valid), 128'd1);
    wait_done(0, 0);

    // Reset mid-EXPAND and mid-ROUNDS, then rerun vector B.
    reset_mid(5);
    reset_mid(15);
    send(CT_B, KEY_B, PT_B);
    wait_done(0, 0);

    // Inputs scrambled and in_valid toggled while busy.
    send(CT_B, KEY_B, PT_B);
    wait_done(1, 1);

    // Randomized traffic with occasional key reuse.
    last_k = KEY_B;
    for (int i = 0; i < 20; i++) begin
      k = ($urandom_range(0, 2) == 0) ? last_k : rnd128();
      c = rnd128();
      send(c, k, ref_dec(c, k));
      wait_done(1, i[0]);
      last_k = k;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
